// File: rtl/control_unit.sv
// Hardwired sequencer for the multi-cycle datapath.
// Fetch T0-T2, opcode latched into T3, execute to T7.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        con_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        r_enable,
  output logic        r_select,
  output logic        BAout,
  output logic        PC_select,
  output logic        HI_select,
  output logic        LO_select,
  output logic        Z_HI_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        InPort_select,
  output logic        c_select,
  output logic [4:0]  alu_instruction,
  output logic        run,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    T0   = 4'h0,
    T1   = 4'h1,
    T2   = 4'h2,
    T3   = 4'h3,
    T4   = 4'h4,
    T5   = 4'h5,
    T6   = 4'h6,
    T7   = 4'h7,
    HALT = 4'hE,
    RST  = 4'hF
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] op;

  logic is_alu;
  logic is_addi;
  logic is_mem;
  logic is_ld;
  logic is_st;
  logic is_br;
  logic is_mfhi;
  logic is_mflo;
  logic is_in;
  logic is_halt;

  assign is_alu  = (op <= 5'b01011);
  assign is_addi = (op == 5'b01100);
  assign is_ld   = (op == 5'b10000);
  assign is_st   = (op == 5'b10001);
  assign is_mem  = is_ld | is_st;
  assign is_br   = (op == 5'b10010);
  assign is_mfhi = (op == 5'b10011);
  assign is_mflo = (op == 5'b10100);
  assign is_in   = (op == 5'b10101);
  assign is_halt = (op == 5'b11111);

  assign step = state;
  assign run  = (state != RST) && (state != HALT);

  // State register and opcode capture at the end of fetch
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RST;
      op    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T2)
        op <= IR_Data[31:27];
    end
  end

  // Next-state and control decode from state and latched opcode
  always_comb begin
    state_nxt           = state;
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    con_enable          = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    HI_enable           = 1'b0;
    LO_enable           = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    Grc                 = 1'b0;
    r_enable            = 1'b0;
    r_select            = 1'b0;
    BAout               = 1'b0;
    PC_select           = 1'b0;
    HI_select           = 1'b0;
    LO_select           = 1'b0;
    Z_HI_select         = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    InPort_select       = 1'b0;
    c_select            = 1'b0;
    alu_instruction     = 5'b00000;
    unique case (state)
      RST: state_nxt = T0;
      T0: begin
        PC_select           = 1'b1;
        MAR_enable          = 1'b1;
        PC_increment_enable = 1'b1;
        state_nxt           = T1;
      end
      T1: begin
        read       = 1'b1;
        MDR_enable = 1'b1;
        state_nxt  = T2;
      end
      T2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
        state_nxt  = T3;
      end
      T3: begin
        state_nxt = T0;
        unique case (1'b1)
          is_alu, is_addi: begin
            Grb       = 1'b1;
            r_select  = 1'b1;
            Y_enable  = 1'b1;
            state_nxt = T4;
          end
          is_mem: begin
            Grb       = 1'b1;
            BAout     = 1'b1;
            Y_enable  = 1'b1;
            state_nxt = T4;
          end
          is_br: begin
            Gra        = 1'b1;
            r_select   = 1'b1;
            con_enable = 1'b1;
            state_nxt  = T4;
          end
          is_mfhi: begin
            HI_select = 1'b1;
            Gra       = 1'b1;
            r_enable  = 1'b1;
          end
          is_mflo: begin
            LO_select = 1'b1;
            Gra       = 1'b1;
            r_enable  = 1'b1;
          end
          is_in: begin
            InPort_select = 1'b1;
            Gra           = 1'b1;
            r_enable      = 1'b1;
          end
          is_halt: state_nxt = HALT;
          default: state_nxt = T0;
        endcase
      end
      T4: begin
        state_nxt = T5;
        unique case (1'b1)
          is_alu: begin
            Grc             = 1'b1;
            r_select        = 1'b1;
            alu_instruction = op;
            Z_enable        = 1'b1;
          end
          is_addi, is_mem: begin
            c_select = 1'b1;
            Z_enable = 1'b1;
          end
          is_br: begin
            PC_select = 1'b1;
            Y_enable  = 1'b1;
          end
          default: state_nxt = T0;
        endcase
      end
      T5: begin
        state_nxt = T0;
        unique case (1'b1)
          is_alu, is_addi: begin
            Z_LO_select = 1'b1;
            Gra         = 1'b1;
            r_enable    = 1'b1;
          end
          is_mem: begin
            Z_LO_select = 1'b1;
            MAR_enable  = 1'b1;
            state_nxt   = T6;
          end
          is_br: begin
            c_select  = 1'b1;
            Z_enable  = 1'b1;
            state_nxt = T6;
          end
          default: state_nxt = T0;
        endcase
      end
      T6: begin
        state_nxt = T0;
        unique case (1'b1)
          is_ld: begin
            read       = 1'b1;
            MDR_enable = 1'b1;
            state_nxt  = T7;
          end
          is_st: begin
            Gra        = 1'b1;
            r_select   = 1'b1;
            MDR_enable = 1'b1;
            state_nxt  = T7;
          end
          is_br: begin
            Z_LO_select = 1'b1;
            PC_enable   = con_output;
          end
          default: state_nxt = T0;
        endcase
      end
      T7: begin
        state_nxt = T0;
        unique case (1'b1)
          is_ld: begin
            MDR_select = 1'b1;
            Gra        = 1'b1;
            r_enable   = 1'b1;
          end
          is_st: write = 1'b1;
          default: state_nxt = T0;
        endcase
      end
      HALT: state_nxt = HALT;
      default: state_nxt = RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Each task walks one instruction and checks its control pattern.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] IR_Data = 32'h0;
  logic        con_output = 1'b0;

  logic PC_enable, PC_increment_enable, IR_enable, con_enable;
  logic Y_enable, Z_enable, MAR_enable, MDR_enable;
  logic HI_enable, LO_enable, read, write;
  logic Gra, Grb, Grc, r_enable, r_select, BAout;
  logic PC_select, HI_select, LO_select, Z_HI_select;
  logic Z_LO_select, MDR_select, InPort_select, c_select;
  logic [4:0] alu_instruction;
  logic       run;
  logic [3:0] step;

  int vec = 0;
  int bad = 0;
  logic write_seen = 1'b0;

  logic [30:0] outs;
  logic [3:0]  nbus;

  assign outs = {PC_enable, PC_increment_enable, IR_enable,
                 con_enable, Y_enable, Z_enable, MAR_enable,
                 MDR_enable, HI_enable, LO_enable, read, write,
                 Gra, Grb, Grc, r_enable, r_select, BAout,
                 PC_select, HI_select, LO_select, Z_HI_select,
                 Z_LO_select, MDR_select, InPort_select,
                 c_select, alu_instruction};
  assign nbus = 4'($countones({PC_select, HI_select, LO_select,
                 Z_HI_select, Z_LO_select, MDR_select,
                 InPort_select, c_select, BAout, r_select}));

  control_unit dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data),
    .con_output(con_output),
    .PC_enable(PC_enable),
    .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .con_enable(con_enable),
    .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .HI_enable(HI_enable), .LO_enable(LO_enable),
    .read(read), .write(write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .r_enable(r_enable), .r_select(r_select), .BAout(BAout),
    .PC_select(PC_select), .HI_select(HI_select),
    .LO_select(LO_select), .Z_HI_select(Z_HI_select),
    .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
    .InPort_select(InPort_select), .c_select(c_select),
    .alu_instruction(alu_instruction),
    .run(run), .step(step)
  );

  always #5 clk = ~clk;

  // Bus contention monitor, sampled mid-cycle
  always @(negedge clk) begin
    vec++;
    if (nbus > 4'd1) begin
      bad++;
      $display("FAIL bus_sources step=%h: got %0d want <=1",
               step, nbus);
    end
  end

  always @(posedge write) write_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_step(input string nm, input logic [3:0] exp);
    vec++;
    if (step !== exp) begin
      bad++;
      $display("FAIL %s: step got %h want %h", nm, step, exp);
    end
  endtask

  task automatic test_reset();
    #2 clr = 1'b1;
    #1;
    vec++;
    if ({outs, run, step} !== {31'h0, 1'b0, 4'hF}) begin
      bad++;
      $display("FAIL reset_async: outs %h run %b step %h",
               outs, run, step);
    end
    tick();
    tick();
    chk_step("reset_hold", 4'hF);
    clr = 1'b0;
    #1;
    vec++;
    if ({write, r_enable, PC_enable, step} !== 7'h0F) begin
      bad++;
      $display("FAIL reset_release: w/re/pce/step %b%b%b %h want 000 f",
               write, r_enable, PC_enable, step);
    end
    tick();
    chk_step("reset_to_t0", 4'h0);
    vec++;
    if ({PC_select, MAR_enable, PC_increment_enable, run} !== 4'hF) begin
      bad++;
      $display("FAIL t0_fetch: got %b want 1111",
               {PC_select, MAR_enable, PC_increment_enable, run});
    end
  endtask

  task automatic test_add();
    IR_Data = 32'h0000_0000;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk_step($sformatf("add_t%0d", i), 4'((i < 6) ? i : 0));
      if (i == 1 && {read, MDR_enable} !== 2'b11) begin
        bad++;
        $display("FAIL t1_fetch: got %b want 11", {read, MDR_enable});
      end
      if (i == 2 && {MDR_select, IR_enable} !== 2'b11) begin
        bad++;
        $display("FAIL t2_fetch: got %b want 11", {MDR_select, IR_enable});
      end
      if (i == 4) begin
        vec++;
        if ({alu_instruction, Z_enable} !== 6'b000001) begin
          bad++;
          $display("FAIL add_t4: alu/z got %b want 000001",
                   {alu_instruction, Z_enable});
        end
      end
      if (i == 5) begin
        vec++;
        if ({Z_LO_select, Gra, r_enable} !== 3'b111) begin
          bad++;
          $display("FAIL add_t5: got %b want 111",
                   {Z_LO_select, Gra, r_enable});
        end
      end
    end
  endtask

  task automatic test_rtype_latch();
    IR_Data = {5'b00011, 27'h123};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk_step($sformatf("rt_t%0d", i), 4'((i < 6) ? i : 0));
      if (i == 3) begin
        vec++;
        if ({Grb, r_select, Y_enable} !== 3'b111) begin
          bad++;
          $display("FAIL rt_t3: got %b want 111",
                   {Grb, r_select, Y_enable});
        end
        IR_Data = 32'hF800_0000;
      end
      if (i == 4) begin
        vec++;
        if ({Grc, r_select, Z_enable, alu_instruction} !== 8'b111_00011) begin
          bad++;
          $display("FAIL rt_t4_latched: got %b want 11100011",
                   {Grc, r_select, Z_enable, alu_instruction});
        end
      end
    end
  endtask

  task automatic test_addi();
    IR_Data = {5'b01100, 27'h0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk_step($sformatf("addi_t%0d", i), 4'((i < 6) ? i : 0));
      if (i == 4) begin
        vec++;
        if ({c_select, Z_enable, r_select, alu_instruction} !== 8'b110_00000) begin
          bad++;
          $display("FAIL addi_t4: got %b want 11000000",
                   {c_select, Z_enable, r_select, alu_instruction});
        end
      end
      if (i == 5) begin
        vec++;
        if ({Z_LO_select, Gra, r_enable} !== 3'b111) begin
          bad++;
          $display("FAIL addi_t5: got %b want 111",
                   {Z_LO_select, Gra, r_enable});
        end
      end
    end
  endtask

  task automatic test_ld();
    IR_Data = {5'b10000, 27'h0};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk_step($sformatf("ld_t%0d", i), 4'((i < 8) ? i : 0));
      if (i == 3) begin
        vec++;
        if ({Grb, BAout, Y_enable, r_select} !== 4'b1110) begin
          bad++;
          $display("FAIL ld_t3: got %b want 1110",
                   {Grb, BAout, Y_enable, r_select});
        end
      end
      if (i == 5) begin
        vec++;
        if ({Z_LO_select, MAR_enable} !== 2'b11) begin
          bad++;
          $display("FAIL ld_t5: got %b want 11", {Z_LO_select, MAR_enable});
        end
      end
      if (i == 6) begin
        vec++;
        if ({read, MDR_enable} !== 2'b11) begin
          bad++;
          $display("FAIL ld_t6: got %b want 11", {read, MDR_enable});
        end
      end
      if (i == 7) begin
        vec++;
        if ({MDR_select, Gra, r_enable} !== 3'b111) begin
          bad++;
          $display("FAIL ld_t7: got %b want 111",
                   {MDR_select, Gra, r_enable});
        end
      end
    end
  endtask

  task automatic test_st();
    IR_Data = {5'b10001, 27'h0};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk_step($sformatf("st_t%0d", i), 4'((i < 8) ? i : 0));
      if (i == 6) begin
        vec++;
        if ({Gra, r_select, MDR_enable, read, write} !== 5'b11100) begin
          bad++;
          $display("FAIL st_t6: got %b want 11100",
                   {Gra, r_select, MDR_enable, read, write});
        end
      end
      if (i == 7) begin
        vec++;
        if (write !== 1'b1) begin
          bad++;
          $display("FAIL st_t7: write got %b want 1", write);
        end
      end
    end
  endtask

  task automatic test_branch(input logic c);
    IR_Data = {5'b10010, 27'h0};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      con_output = (i == 6) ? c : ~c;
      #1;
      chk_step($sformatf("br%0d_t%0d", c, i), 4'((i < 7) ? i : 0));
      vec++;
      if (PC_enable !== ((i == 6) ? c : 1'b0)) begin
        bad++;
        $display("FAIL br%0d_pce_t%0d: got %b want %b",
                 c, i, PC_enable, (i == 6) ? c : 1'b0);
      end
      if (i == 3 && {Gra, r_select, con_enable} !== 3'b111) begin
        bad++;
        $display("FAIL br_t3: got %b want 111",
                 {Gra, r_select, con_enable});
      end
      if (i == 4 && {PC_select, Y_enable} !== 2'b11) begin
        bad++;
        $display("FAIL br_t4: got %b want 11", {PC_select, Y_enable});
      end
      if (i == 6 && Z_LO_select !== 1'b1) begin
        bad++;
        $display("FAIL br_t6: zlo got %b want 1", Z_LO_select);
      end
    end
    con_output = 1'b0;
  endtask

  task automatic test_short_ops();
    logic [4:0] ops [6] = '{5'b10011, 5'b10100, 5'b10101,
                            5'b11010, 5'b01101, 5'b10110};
    logic [4:0] exp [6] = '{5'b10011, 5'b01011, 5'b00111,
                            5'b00000, 5'b00000, 5'b00000};
    for (int j = 0; j < 6; j++) begin
      IR_Data = {ops[j], 27'h0};
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        chk_step($sformatf("op%b_t%0d", ops[j], i), 4'((i < 4) ? i : 0));
        if (i == 3) begin
          vec++;
          if ({HI_select, LO_select, InPort_select, Gra, r_enable} !== exp[j]
              || run !== 1'b1
              || outs[30:0] !== {26'({HI_select, LO_select, InPort_select, Gra, r_enable} != 0 ? outs[30:5] : 26'h0), 5'h0}) begin
            bad++;
            $display("FAIL op%b_t3: got %b run %b want %b run 1",
                     ops[j], {HI_select, LO_select, InPort_select, Gra, r_enable},
                     run, exp[j]);
          end
        end
      end
    end
  endtask

  task automatic test_halt();
    IR_Data = {5'b11111, 27'h0};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk_step($sformatf("halt_t%0d", i), 4'(i));
    end
    for (int k = 0; k < 11; k++) begin
      tick();
      vec++;
      if ({outs, run, step} !== {31'h0, 1'b0, 4'hE}) begin
        bad++;
        $display("FAIL halt_hold%0d: outs %h run %b step %h want 0 0 e",
                 k, outs, run, step);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_step("halt_clr", 4'hF);
    tick();
    chk_step("halt_restart", 4'h0);
  endtask

  task automatic test_clr_mid_st();
    IR_Data = {5'b10001, 27'h0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk_step($sformatf("abort_t%0d", i), 4'(i));
    end
    write_seen = 1'b0;
    #3 clr = 1'b1;
    #1;
    vec++;
    if ({outs, run, step} !== {31'h0, 1'b0, 4'hF}) begin
      bad++;
      $display("FAIL abort_async: outs %h run %b step %h want 0 0 f",
               outs, run, step);
    end
    tick();
    chk_step("abort_hold", 4'hF);
    clr = 1'b0;
    #1;
    vec++;
    if ({write, r_enable, PC_enable} !== 3'b000) begin
      bad++;
      $display("FAIL abort_release: got %b want 000",
               {write, r_enable, PC_enable});
    end
    tick();
    chk_step("abort_to_t0", 4'h0);
    vec++;
    if (write_seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_write: write_seen %b want 0", write_seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype_latch();
    test_addi();
    test_ld();
    test_st();
    test_branch(1'b0);
    test_branch(1'b1);
    test_short_ops();
    test_halt();
    test_clr_mid_st();
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
